// File: rtl/cmp_config_loader_if.sv
// Signal bundle between the config loader, its input byte FIFO and the comparator memory.
// Width defaults for the global hash defines apply only when the build does not supply them.
`ifndef NUM_HASHES
`define NUM_HASHES 8
`endif
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 2
`endif
`ifndef HASH_COUNT_MSB
`define HASH_COUNT_MSB 3
`endif

interface cmp_config_loader_if;
    logic [7:0]                 din;
    logic                       empty;
    logic                       rd_en;
    logic                       cmp_idle;
    logic                       busy;
    logic [7:0]                 dout;
    logic                       wr_en;
    logic [`HASH_NUM_MSB+2:0]   wr_addr;
    logic [`HASH_COUNT_MSB:0]   hash_count;
    logic                       loaded;
    logic                       done;
    logic                       error;

    modport master (
        input  din, empty, cmp_idle,
        output rd_en, busy, dout, wr_en, wr_addr, hash_count, loaded, done, error
    );

    modport slave (
        output din, empty, cmp_idle,
        input  rd_en, busy, dout, wr_en, wr_addr, hash_count, loaded, done, error
    );
endinterface

// File: rtl/cmp_config_loader.sv
// Parses comparator-configuration packets from a FWFT byte FIFO into the comparator hash memory.
// Optional feature macro: CMP_CONFIG_CHECKSUM_EN adds an XOR checksum byte before the terminator.
`ifndef NUM_HASHES
`define NUM_HASHES 8
`endif
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 2
`endif
`ifndef HASH_COUNT_MSB
`define HASH_COUNT_MSB 3
`endif

module cmp_config_loader #(
    parameter logic [7:0] MAGIC = 8'hCC
) (
    input  logic                CLK,
    input  logic                RST,
    cmp_config_loader_if.master bus
);

    localparam int PTR_W = `HASH_NUM_MSB + 3;
    localparam int HC_W  = `HASH_COUNT_MSB + 1;
    localparam logic [15:0] MAX_N = 16'(`NUM_HASHES);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        WAIT_IDLE,
        DATA,
`ifdef CMP_CONFIG_CHECKSUM_EN
        CHECKSUM,
`endif
        TERM,
        DRAIN
    } state_t;

    state_t           state;
    logic [7:0]       cnt_lo;
    logic [15:0]      hdr_n;
    logic [HC_W-1:0]  n_hc;
    logic [PTR_W-1:0] byte_ptr;
    logic [PTR_W-1:0] last_ptr;
    logic             pop;
`ifdef CMP_CONFIG_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign hdr_n     = {bus.din, cnt_lo};
    assign pop       = !bus.empty && (state != WAIT_IDLE);
    assign bus.rd_en = pop && !RST;
    assign bus.busy  = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            cnt_lo         <= '0;
            n_hc           <= '0;
            byte_ptr       <= '0;
            last_ptr       <= '0;
            bus.dout       <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.hash_count <= '0;
            bus.loaded     <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            if (state == WAIT_IDLE) begin
                // Holding here keeps busy high, so the comparator cannot be started under us.
                if (bus.cmp_idle) state <= DATA;
            end else if (pop) begin
                case (state)
                    IDLE: begin
                        cnt_lo    <= bus.din;
                        bus.error <= 1'b0;
                        state     <= CNT_HI;
                    end
                    CNT_HI: begin
                        byte_ptr <= '0;
                        n_hc     <= HC_W'(hdr_n);
                        last_ptr <= PTR_W'({hdr_n, 2'b00} - 18'd1);
`ifdef CMP_CONFIG_CHECKSUM_EN
                        csum     <= '0;
`endif
                        if (hdr_n == 16'd0 || hdr_n > MAX_N) begin
                            bus.error <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            state     <= WAIT_IDLE;
                        end
                    end
                    DATA: begin
                        bus.dout    <= bus.din;
                        bus.wr_addr <= byte_ptr;
                        bus.wr_en   <= 1'b1;
                        byte_ptr    <= byte_ptr + 1'b1;
`ifdef CMP_CONFIG_CHECKSUM_EN
                        csum        <= csum ^ bus.din;
                        if (byte_ptr == last_ptr) state <= CHECKSUM;
`else
                        if (byte_ptr == last_ptr) state <= TERM;
`endif
                    end
`ifdef CMP_CONFIG_CHECKSUM_EN
                    CHECKSUM: begin
                        if (bus.din != csum) begin
                            bus.error <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            state     <= TERM;
                        end
                    end
`endif
                    TERM: begin
                        if (bus.din == MAGIC) begin
                            bus.hash_count <= n_hc;
                            bus.loaded     <= 1'b1;
                            bus.done       <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            bus.error      <= 1'b1;
                            state          <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (bus.din == MAGIC) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmp_config_loader.sv
// Self-checking bench for cmp_config_loader: packet table plus hand-written stall/reset sequences.
`ifndef NUM_HASHES
`define NUM_HASHES 8
`endif
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 2
`endif
`ifndef HASH_COUNT_MSB
`define HASH_COUNT_MSB 3
`endif

module tb_cmp_config_loader;

    localparam logic [7:0] MAGIC = 8'hCC;
    localparam int PTR_W = `HASH_NUM_MSB + 3;
    localparam int HC_W  = `HASH_COUNT_MSB + 1;
    localparam int NH    = `NUM_HASHES;

    typedef struct packed {
        logic [PTR_W-1:0] addr;
        logic [7:0]       data;
    } wr_t;

    typedef struct {
        logic [15:0]     n;
        logic [7:0]      base;
        logic [7:0]      term;
        int              junk;
        bit              bad_csum;
        bit              exp_err;
        logic [HC_W-1:0] exp_hc;
        int              exp_done;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cmp_config_loader_if bus();

    cmp_config_loader #(.MAGIC(MAGIC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    logic [7:0] fifo_q[$];
    wr_t        sb_q[$];
    wr_t        sb_e;
    vec_t       vecs[$];
    logic       hold_empty = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] n, input logic [7:0] base, input logic [7:0] term,
                                input int junk, input bit bad, input bit err, input int hc, input int dn);
        vec_t v;
        v.n = n; v.base = base; v.term = term; v.junk = junk; v.bad_csum = bad;
        v.exp_err = err; v.exp_hc = HC_W'(hc); v.exp_done = dn;
        return v;
    endfunction

    task automatic drive();
        bus.empty = hold_empty || (fifo_q.size() == 0);
        bus.din   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic tick();
        logic pop;
        @(posedge CLK);
        pop = bus.rd_en;
        #1;
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive();
    endtask

    // Scoreboard: every memory write must match the oldest expected {addr, data}.
    always @(negedge CLK) begin
        if (bus.done) done_cnt++;
        if (bus.wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: got write addr %0d data %0h, required none", bus.wr_addr, bus.dout);
            end else begin
                sb_e = sb_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(sb_e.addr));
                check("wr_data", 32'(bus.dout), 32'(sb_e.data));
            end
        end
    end

    task automatic send_vec(input vec_t v);
        logic [7:0] b;
        logic [7:0] x;
        bit ok_n;
        fifo_q.push_back(v.n[7:0]);
        fifo_q.push_back(v.n[15:8]);
        ok_n = (v.n != 16'd0) && (int'(v.n) <= NH);
        x = 8'h00;
        if (ok_n) begin
            for (int i = 0; i < int'(v.n) * 4; i++) begin
                b = 8'(int'(v.base) + i);
                fifo_q.push_back(b);
                sb_q.push_back('{addr: PTR_W'(i), data: b});
                x = x ^ b;
            end
`ifdef CMP_CONFIG_CHECKSUM_EN
            fifo_q.push_back(v.bad_csum ? ~x : x);
`endif
            if (!v.bad_csum) fifo_q.push_back(v.term);
        end
        for (int i = 0; i < v.junk; i++) fifo_q.push_back(8'(8'h55 ^ i));
        if (!ok_n || v.bad_csum || v.term != MAGIC) fifo_q.push_back(MAGIC);
        drive();
    endtask

    task automatic wait_done(input string name, input bit toggle, output int cycles);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || bus.busy) && k < 2000) begin
            if (toggle) begin
                hold_empty = ~hold_empty;
                drive();
            end
            tick();
            k++;
        end
        hold_empty = 1'b0;
        drive();
        if (k >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy=%0b fifo=%0d, required idle", name, bus.busy, fifo_q.size());
        end
        cycles = k;
        tick();
    endtask

    task automatic finish_vec(input vec_t v, input int d0, input string name, input bit toggle);
        int cyc;
        wait_done(name, toggle, cyc);
        check({name, "_error"}, 32'(bus.error), 32'(v.exp_err));
        check({name, "_hash_count"}, 32'(bus.hash_count), 32'(v.exp_hc));
        check({name, "_loaded"}, 32'(bus.loaded), 32'd1);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'(v.exp_done));
        check({name, "_pending_writes"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        int d0;
        d0 = done_cnt;
        send_vec(v);
        finish_vec(v, d0, name, 1'b0);
    endtask

    initial begin
        int d0;
        int w0;
        int k;
        int cyc;
        vec_t v;

        vecs.push_back(mk(16'd2,   8'h11, MAGIC, 0, 0, 0, 2, 1));
        vecs.push_back(mk(16'd0,   8'h00, MAGIC, 0, 0, 1, 2, 0));
        vecs.push_back(mk(16'd1,   8'h21, MAGIC, 0, 0, 0, 1, 1));
        vecs.push_back(mk(16'd1,   8'h31, 8'h00, 3, 0, 1, 1, 0));
        vecs.push_back(mk(16'(NH + 1), 8'h00, MAGIC, 2, 0, 1, 1, 0));
        vecs.push_back(mk(16'(NH), 8'h40, MAGIC, 0, 0, 0, NH, 1));
        vecs.push_back(mk(16'd257, 8'h00, MAGIC, 0, 0, 1, NH, 0));
        vecs.push_back(mk(16'd3,   8'h80, MAGIC, 0, 0, 0, 3, 1));
`ifdef CMP_CONFIG_CHECKSUM_EN
        vecs.push_back(mk(16'd2,   8'h90, MAGIC, 1, 1, 1, 3, 0));
        vecs.push_back(mk(16'd1,   8'hA0, MAGIC, 0, 0, 0, 1, 1));
`endif

        bus.cmp_idle = 1'b1;
        drive();
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_hash_count", 32'(bus.hash_count), 32'd0);
        check("rst_loaded", 32'(bus.loaded), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);

        // First packet is queued while reset is still held: nothing may be popped.
        d0 = done_cnt;
        send_vec(vecs[0]);
        tick();
        check("rst_rd_en_nonempty", 32'(bus.rd_en), 32'd0);
        RST = 1'b0;
        finish_vec(vecs[0], d0, "vec0", 1'b0);

        for (int i = 1; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back N=2 packet with FIFO never empty: header, one wait state, 8 data, terminator.
        v = mk(16'd2, 8'h11, MAGIC, 0, 0, 0, 2, 1);
        send_vec(v);
        wait_done("nobubble", 1'b0, cyc);
`ifdef CMP_CONFIG_CHECKSUM_EN
        check("nobubble_cycles", 32'(cyc), 32'd13);
`else
        check("nobubble_cycles", 32'(cyc), 32'd12);
`endif
        check("nobubble_hash_count", 32'(bus.hash_count), 32'd2);

        // Comparator busy: loader must park after the header without reading.
        bus.cmp_idle = 1'b0;
        v = mk(16'd1, 8'hB0, MAGIC, 0, 0, 0, 1, 1);
        d0 = done_cnt;
        send_vec(v);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_rd_en", 32'(bus.rd_en), 32'd0);
            check("stall_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check("stall_wr_en", 32'(bus.wr_en), 32'd0);
        bus.cmp_idle = 1'b1;
        tick();
        check("resume_wr_en_first", 32'(bus.wr_en), 32'd0);
        check("resume_rd_en", 32'(bus.rd_en), 32'd1);
        tick();
        check("resume_wr_en", 32'(bus.wr_en), 32'd1);
        check("resume_wr_addr", 32'(bus.wr_addr), 32'd0);
        finish_vec(v, d0, "stall", 1'b0);

        // FIFO empty every other cycle: writes must neither duplicate nor skip.
        v = mk(16'd3, 8'hD0, MAGIC, 0, 0, 0, 3, 1);
        d0 = done_cnt;
        w0 = wr_cnt;
        send_vec(v);
        finish_vec(v, d0, "gappy", 1'b1);
        check("gappy_write_count", 32'(wr_cnt - w0), 32'd12);

        // Reset mid-packet after five data writes.
        v = mk(16'd4, 8'h60, MAGIC, 0, 0, 0, 4, 1);
        send_vec(v);
        w0 = wr_cnt;
        k = 0;
        while (wr_cnt - w0 < 5 && k < 200) begin
            tick();
            k++;
        end
        check("midrst_reached_5_writes", 32'(wr_cnt - w0 >= 5), 32'd1);
        RST = 1'b1;
        #1;
        check("midrst_rd_en", 32'(bus.rd_en), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("midrst_dout", 32'(bus.dout), 32'd0);
        check("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("midrst_hash_count", 32'(bus.hash_count), 32'd0);
        check("midrst_loaded", 32'(bus.loaded), 32'd0);
        check("midrst_error", 32'(bus.error), 32'd0);
        tick();
        tick();
        fifo_q.delete();
        sb_q.delete();
        drive();
        RST = 1'b0;
        tick();
        apply_vec(mk(16'd1, 8'h70, MAGIC, 0, 0, 0, 1, 1), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
